// File: rtl/subr4u_serial.sv
// Digit-serial unsigned subtractor: D = A - B mod 2^WIDTH, borrow = (A < B), DIGIT bits per cycle LSB first.
// Optional duplicate borrow chain with sticky fault flag under `define SUBR_FAULT_CHECK_EN.
module subr4u_serial #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             fault_err
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid, once raised, holds with its data stable until that edge.

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("subr4u_serial: WIDTH must be >= 2 and divisible by DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             out_valid_q, out_valid_d;

    logic                   accept;
    logic                   run_step;
    logic                   res_hand;
    logic [DIGIT:0]         digit_full;
    logic [DIGIT-1:0]       diff_dig;
    logic                   bo;
    logic [WIDTH+DIGIT-1:0] res_cat;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        accept    = in_valid && (state_q == IDLE);
        run_step  = (state_q == RUN);
        res_hand  = (state_q == DONE) && out_valid_q && out_ready;
    end

    // One-digit borrow-ripple cell; the extra MSB of the difference is the borrow out.
    always_comb begin
        digit_full = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, br_q};
        diff_dig   = digit_full[DIGIT-1:0];
        bo         = digit_full[DIGIT];
        res_cat    = {diff_dig, res_q};
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            res_d = '0;
            cnt_d = '0;
            br_d  = 1'b0;
        end
        if (run_step) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            res_d = res_cat[WIDTH+DIGIT-1:DIGIT];
            br_d  = bo;
            cnt_d = cnt_q + CW'(1);
        end
        // The first DONE cycle copies the finished result into the output registers.
        if ((state_q == DONE) && !out_valid_q) begin
            out_valid_d = 1'b1;
            d_d         = res_q;
            borrow_d    = br_q;
        end
        if (res_hand) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d      = d_q;
    assign borrow = borrow_q;

`ifdef SUBR_FAULT_CHECK_EN
    logic brc_q, brc_d;
    logic bo_dup;
    logic fault_q, fault_d;

    // Boolean-form borrow chain on its own flop, so a stuck or upset br_q shows up as disagreement.
    always_comb begin
        bo_dup = brc_q;
        for (int i = 0; i < DIGIT; i++) begin
            bo_dup = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bo_dup);
        end
        brc_d = brc_q;
        if (accept) begin
            brc_d = 1'b0;
        end
        if (run_step) begin
            brc_d = bo_dup;
        end
        fault_d = fault_q | (run_step && (bo != bo_dup));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brc_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            brc_q   <= brc_d;
            fault_q <= fault_d;
        end
    end

    assign fault_err = fault_q;
`else
    assign fault_err = 1'b0;
`endif

endmodule
